// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage between execute and write-back.
//
// Decodes the execute-stage load/store side-band, issues one access at a time
// on a ready-handshaked 64-bit data-memory port, and stalls the pipeline while
// the access is in flight. Non-memory results pass to write-back after one
// register stage. Load data is extracted from the returned 64-bit beat and
// sign- or zero-extended.
//
// Optional build macro: MEM_MISALIGN_TRAP_EN
//   defined   - accesses whose EA is not a multiple of the size raise a one-cycle
//               MisalignOut pulse and issue no bus request.
//   undefined - EA low bits are forced to natural alignment; MisalignOut is 0.
//
// Ports:
//   Clk, Rst              clock, synchronous active-low reset
//   ValidIn .. RdWriteDataIn   execute-stage side-band and ALU result
//   HoldFlagToCtrl        combinational stall request to the pipeline controller
//   RdAddrOut/RdWriteEnableOut/RdWriteDataOut  registered write-back
//   MemReqOut/MemWeOut/MemAddrOut/MemWdataOut/MemWmaskOut  data-memory request
//   MemReadyIn/MemRdataIn  data-memory response
//   BusErrOut             one-cycle pulse on access timeout
//   MisalignOut           one-cycle pulse on trapped misaligned access

module mem_access_unit #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ValidIn,
  input  logic [6:0]  OpCodeIn,
  input  logic [2:0]  Funct3In,
  input  logic [63:0] ImmIn,
  input  logic [63:0] Rs1ReadDataIn,
  input  logic [63:0] Rs2ReadDataIn,
  input  logic [4:0]  RdAddrIn,
  input  logic        RdWriteEnableIn,
  input  logic [63:0] RdWriteDataIn,
  output logic        HoldFlagToCtrl,
  output logic [4:0]  RdAddrOut,
  output logic        RdWriteEnableOut,
  output logic [63:0] RdWriteDataOut,
  output logic        MemReqOut,
  output logic        MemWeOut,
  output logic [63:0] MemAddrOut,
  output logic [63:0] MemWdataOut,
  output logic [7:0]  MemWmaskOut,
  input  logic        MemReadyIn,
  input  logic [63:0] MemRdataIn,
  output logic        BusErrOut,
  output logic        MisalignOut
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  // State and capture registers
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [2:0]        r_shift;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [7:0]        r_wmask;
  logic [4:0]        r_cap_rd_addr;
  logic              r_cap_rd_en;
  logic [4:0]        r_rd_addr;
  logic              r_rd_en;
  logic [XLEN-1:0]   r_rd_data;
  logic              r_bus_err;
  logic              r_misalign;

  // Next-state values
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_we_nxt;
  logic [1:0]        w_size_nxt;
  logic              w_unsigned_nxt;
  logic [2:0]        w_shift_nxt;
  logic [XLEN-1:0]   w_addr_nxt;
  logic [XLEN-1:0]   w_wdata_nxt;
  logic [7:0]        w_wmask_nxt;
  logic [4:0]        w_cap_rd_addr_nxt;
  logic              w_cap_rd_en_nxt;
  logic [4:0]        w_rd_addr_nxt;
  logic              w_rd_en_nxt;
  logic [XLEN-1:0]   w_rd_data_nxt;
  logic              w_bus_err_nxt;
  logic              w_misalign_nxt;
  logic              w_hold;

  // Decode and address formatting
  logic [XLEN-1:0]   w_ea;
  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_mem;
  logic [1:0]        w_size;
  logic [2:0]        w_align_bits;
  logic [2:0]        w_ofs;
  logic [7:0]        w_size_mask;
  logic              w_trap;
  logic              w_timeout;
  logic [XLEN-1:0]   w_rshift;
  logic [XLEN-1:0]   w_load_data;

  assign w_ea       = Rs1ReadDataIn + ImmIn;
  assign w_is_load  = (OpCodeIn == OPC_LOAD) && (Funct3In != 3'b111);
  assign w_is_store = (OpCodeIn == OPC_STORE) && !Funct3In[2];
  assign w_is_mem   = w_is_load || w_is_store;
  assign w_size     = Funct3In[1:0];

  // Low EA bits that must be zero for a naturally aligned access
  always_comb begin
    w_align_bits = 3'b111;
    w_size_mask  = 8'hFF;
    case (w_size)
      2'd0: begin w_align_bits = 3'b000; w_size_mask = 8'h01; end
      2'd1: begin w_align_bits = 3'b001; w_size_mask = 8'h03; end
      2'd2: begin w_align_bits = 3'b011; w_size_mask = 8'h0F; end
      default: begin w_align_bits = 3'b111; w_size_mask = 8'hFF; end
    endcase
  end

  // Masking is a no-op for aligned accesses, so one offset serves both builds
  assign w_ofs = w_ea[2:0] & ~w_align_bits;

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap = |(w_ea[2:0] & w_align_bits);
`else
  assign w_trap = 1'b0;
`endif

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Load extraction: move the addressed bytes to the bottom, then extend
  assign w_rshift = MemRdataIn >> {r_shift, 3'b000};

  always_comb begin
    w_load_data = w_rshift;
    case (r_size)
      2'd0: w_load_data = r_unsigned ? {56'd0, w_rshift[7:0]}
                                     : {{56{w_rshift[7]}}, w_rshift[7:0]};
      2'd1: w_load_data = r_unsigned ? {48'd0, w_rshift[15:0]}
                                     : {{48{w_rshift[15]}}, w_rshift[15:0]};
      2'd2: w_load_data = r_unsigned ? {32'd0, w_rshift[31:0]}
                                     : {{32{w_rshift[31]}}, w_rshift[31:0]};
      default: w_load_data = w_rshift;
    endcase
  end

  // Next-state, capture and write-back logic
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_we_nxt          = r_we;
    w_size_nxt        = r_size;
    w_unsigned_nxt    = r_unsigned;
    w_shift_nxt       = r_shift;
    w_addr_nxt        = r_addr;
    w_wdata_nxt       = r_wdata;
    w_wmask_nxt       = r_wmask;
    w_cap_rd_addr_nxt = r_cap_rd_addr;
    w_cap_rd_en_nxt   = r_cap_rd_en;
    w_rd_addr_nxt     = r_rd_addr;
    w_rd_en_nxt       = r_rd_en;
    w_rd_data_nxt     = r_rd_data;
    w_bus_err_nxt     = 1'b0;
    w_misalign_nxt    = 1'b0;
    w_hold            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (ValidIn) begin
          if (w_is_mem) begin
            w_rd_en_nxt = 1'b0;
            if (w_trap) begin
              w_misalign_nxt = 1'b1;
            end else begin
              w_hold            = 1'b1;
              w_state_nxt       = S_REQ;
              w_cnt_nxt         = '0;
              w_we_nxt          = w_is_store;
              w_size_nxt        = w_size;
              w_unsigned_nxt    = Funct3In[2];
              w_shift_nxt       = w_ofs;
              w_addr_nxt        = {w_ea[XLEN-1:3], 3'b000};
              w_wdata_nxt       = Rs2ReadDataIn << {w_ofs, 3'b000};
              w_wmask_nxt       = w_size_mask << w_ofs;
              w_cap_rd_addr_nxt = RdAddrIn;
              w_cap_rd_en_nxt   = RdWriteEnableIn;
            end
          end else begin
            w_rd_addr_nxt = RdAddrIn;
            w_rd_en_nxt   = RdWriteEnableIn;
            w_rd_data_nxt = RdWriteDataIn;
          end
        end else begin
          w_rd_en_nxt = 1'b0;
        end
      end

      S_REQ: begin
        // Ready on the final timeout cycle still completes the access
        if (MemReadyIn) begin
          w_state_nxt = S_IDLE;
          if (!r_we) begin
            w_rd_addr_nxt = r_cap_rd_addr;
            w_rd_en_nxt   = r_cap_rd_en;
            w_rd_data_nxt = w_load_data;
          end else begin
            w_rd_en_nxt = 1'b0;
          end
        end else if (w_timeout) begin
          // Hold is released in the abort cycle so the pipeline moves on
          w_state_nxt   = S_IDLE;
          w_bus_err_nxt = 1'b1;
          w_rd_en_nxt   = 1'b0;
        end else begin
          w_hold    = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_we          <= 1'b0;
      r_size        <= 2'd0;
      r_unsigned    <= 1'b0;
      r_shift       <= 3'd0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wmask       <= 8'd0;
      r_cap_rd_addr <= 5'd0;
      r_cap_rd_en   <= 1'b0;
      r_rd_addr     <= 5'd0;
      r_rd_en       <= 1'b0;
      r_rd_data     <= '0;
      r_bus_err     <= 1'b0;
      r_misalign    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_we          <= w_we_nxt;
      r_size        <= w_size_nxt;
      r_unsigned    <= w_unsigned_nxt;
      r_shift       <= w_shift_nxt;
      r_addr        <= w_addr_nxt;
      r_wdata       <= w_wdata_nxt;
      r_wmask       <= w_wmask_nxt;
      r_cap_rd_addr <= w_cap_rd_addr_nxt;
      r_cap_rd_en   <= w_cap_rd_en_nxt;
      r_rd_addr     <= w_rd_addr_nxt;
      r_rd_en       <= w_rd_en_nxt;
      r_rd_data     <= w_rd_data_nxt;
      r_bus_err     <= w_bus_err_nxt;
      r_misalign    <= w_misalign_nxt;
    end
  end

  // Hold is forced low while reset is asserted
  assign HoldFlagToCtrl   = Rst & w_hold;
  assign RdAddrOut        = r_rd_addr;
  assign RdWriteEnableOut = r_rd_en;
  assign RdWriteDataOut   = r_rd_data;
  assign MemReqOut        = (r_state == S_REQ);
  assign MemWeOut         = r_we;
  assign MemAddrOut       = r_addr;
  assign MemWdataOut      = r_wdata;
  assign MemWmaskOut      = r_wmask;
  assign BusErrOut        = r_bus_err;
  assign MisalignOut      = r_misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against an
// instruction-level reference model.

module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        Clk;
  logic        Rst;
  logic        ValidIn;
  logic [6:0]  OpCodeIn;
  logic [2:0]  Funct3In;
  logic [63:0] ImmIn;
  logic [63:0] Rs1ReadDataIn;
  logic [63:0] Rs2ReadDataIn;
  logic [4:0]  RdAddrIn;
  logic        RdWriteEnableIn;
  logic [63:0] RdWriteDataIn;
  logic        HoldFlagToCtrl;
  logic [4:0]  RdAddrOut;
  logic        RdWriteEnableOut;
  logic [63:0] RdWriteDataOut;
  logic        MemReqOut;
  logic        MemWeOut;
  logic [63:0] MemAddrOut;
  logic [63:0] MemWdataOut;
  logic [7:0]  MemWmaskOut;
  logic        MemReadyIn;
  logic [63:0] MemRdataIn;
  logic        BusErrOut;
  logic        MisalignOut;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .ValidIn          (ValidIn),
    .OpCodeIn         (OpCodeIn),
    .Funct3In         (Funct3In),
    .ImmIn            (ImmIn),
    .Rs1ReadDataIn    (Rs1ReadDataIn),
    .Rs2ReadDataIn    (Rs2ReadDataIn),
    .RdAddrIn         (RdAddrIn),
    .RdWriteEnableIn  (RdWriteEnableIn),
    .RdWriteDataIn    (RdWriteDataIn),
    .HoldFlagToCtrl   (HoldFlagToCtrl),
    .RdAddrOut        (RdAddrOut),
    .RdWriteEnableOut (RdWriteEnableOut),
    .RdWriteDataOut   (RdWriteDataOut),
    .MemReqOut        (MemReqOut),
    .MemWeOut         (MemWeOut),
    .MemAddrOut       (MemAddrOut),
    .MemWdataOut      (MemWdataOut),
    .MemWmaskOut      (MemWmaskOut),
    .MemReadyIn       (MemReadyIn),
    .MemRdataIn       (MemRdataIn),
    .BusErrOut        (BusErrOut),
    .MisalignOut      (MisalignOut)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding access plus expected write-back state
  bit          m_busy = 0;
  bit          m_load = 0;
  int          m_bytes = 1;
  bit          m_uns = 0;
  logic [63:0] m_ea = '0;
  logic [63:0] m_rs2 = '0;
  logic [4:0]  m_rd = '0;
  logic        m_rden = 0;
  int          m_waited = 0;
  logic [4:0]  e_rd = '0;
  logic        e_en = 0;
  logic [63:0] e_data = '0;
  logic        e_buserr = 0;
  logic        e_mis = 0;

  // Byte-by-byte gather of the addressed bytes, then extension
  function automatic logic [63:0] extract(input logic [63:0] beat, input int off,
                                          input int bytes, input bit uns);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < bytes; i++) v[8*i +: 8] = beat[8*(off+i) +: 8];
    if (!uns && bytes < 8 && v[8*bytes-1] == 1'b1)
      for (int i = bytes; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // Per-cycle compare against the model, then advance the model by one edge
  initial begin : compare
    bit          primed;
    bit          isld, isst, trap;
    int          bytes, off;
    logic [63:0] ea;
    logic        hold_exp;
    primed = 0;
    forever begin
      @(negedge Clk);
      isld  = ValidIn && OpCodeIn == 7'b0000011 && Funct3In != 3'd7;
      isst  = ValidIn && OpCodeIn == 7'b0100011 && Funct3In < 3'd4;
      bytes = 1 << Funct3In[1:0];
      ea    = Rs1ReadDataIn + ImmIn;
`ifdef MEM_MISALIGN_TRAP_EN
      trap  = (ea % 64'(bytes)) != 0;
`else
      trap  = 0;
      ea    = ea - (ea % 64'(bytes));
`endif
      if (!Rst)        hold_exp = 1'b0;
      else if (m_busy) hold_exp = !MemReadyIn && (m_waited != TO - 1);
      else             hold_exp = (isld || isst) && !trap;

      if (primed) begin
        chk("m_hold", 64'(HoldFlagToCtrl), 64'(hold_exp));
        chk("m_req", 64'(MemReqOut), 64'(m_busy));
        chk("m_wb_en", 64'(RdWriteEnableOut), 64'(e_en));
        chk("m_buserr", 64'(BusErrOut), 64'(e_buserr));
        chk("m_misalign", 64'(MisalignOut), 64'(e_mis));
        if (e_en) begin
          chk("m_wb_rd", 64'(RdAddrOut), 64'(e_rd));
          chk("m_wb_data", RdWriteDataOut, e_data);
        end
        if (m_busy) begin
          off = int'(m_ea % 64'd8);
          chk("m_addr", MemAddrOut, m_ea - (m_ea % 64'd8));
          chk("m_we", 64'(MemWeOut), 64'(!m_load));
          chk("m_wmask", 64'(MemWmaskOut), 64'(((2 ** m_bytes) - 1) << off));
          if (!m_load) chk("m_wdata", MemWdataOut, m_rs2 << (8 * off));
        end
      end

      e_buserr = 0;
      e_mis    = 0;
      if (!Rst) begin
        m_busy = 0; e_rd = '0; e_en = 0; e_data = '0;
      end else if (m_busy) begin
        if (MemReadyIn) begin
          m_busy = 0;
          if (m_load) begin
            e_rd   = m_rd;
            e_en   = m_rden;
            e_data = extract(MemRdataIn, int'(m_ea % 64'd8), m_bytes, m_uns);
          end else begin
            e_en = 0;
          end
        end else if (m_waited == TO - 1) begin
          m_busy = 0; e_buserr = 1; e_en = 0;
        end else begin
          m_waited++;
        end
      end else if (ValidIn) begin
        if (isld || isst) begin
          e_en = 0;
          if (trap) e_mis = 1;
          else begin
            m_busy = 1; m_load = isld; m_bytes = bytes; m_uns = Funct3In[2];
            m_ea = ea; m_rs2 = Rs2ReadDataIn; m_rd = RdAddrIn;
            m_rden = RdWriteEnableIn; m_waited = 0;
          end
        end else begin
          e_rd = RdAddrIn; e_en = RdWriteEnableIn; e_data = RdWriteDataIn;
        end
      end else begin
        e_en = 0;
      end
      primed = 1;
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_idle();
    ValidIn = 0; OpCodeIn = '0; Funct3In = '0; ImmIn = '0;
    Rs1ReadDataIn = '0; Rs2ReadDataIn = '0; RdAddrIn = '0;
    RdWriteEnableIn = 0; RdWriteDataIn = '0;
  endtask

  task automatic set_op(input logic [6:0] op, input logic [2:0] f3,
                        input logic [63:0] rs1, input logic [63:0] imm,
                        input logic [63:0] rs2, input logic [4:0] rd,
                        input logic [63:0] alu);
    ValidIn = 1; OpCodeIn = op; Funct3In = f3; ImmIn = imm;
    Rs1ReadDataIn = rs1; Rs2ReadDataIn = rs2; RdAddrIn = rd;
    RdWriteEnableIn = 1; RdWriteDataIn = alu;
  endtask

  // LB/LBU at EA 0x1003 with zero wait states
  task automatic do_byte_load(input logic [2:0] f3, input logic [63:0] exp, input string tag);
    set_op(7'b0000011, f3, 64'h1000, 64'd3, 64'd0, 5'd7, 64'd0);
    MemReadyIn = 1; MemRdataIn = 64'h0000_0000_8000_0000;
    #1 chk({tag, "_acc_hold"}, 64'(HoldFlagToCtrl), 64'h1);
    cyc();
    set_idle();
    chk({tag, "_req"}, 64'(MemReqOut), 64'h1);
    chk({tag, "_addr"}, MemAddrOut, 64'h1000);
    #1 chk({tag, "_req_hold"}, 64'(HoldFlagToCtrl), 64'h0);
    cyc();
    MemReadyIn = 0;
    chk({tag, "_data"}, RdWriteDataOut, exp);
    chk({tag, "_en"}, 64'(RdWriteEnableOut), 64'h1);
    chk({tag, "_rd"}, 64'(RdAddrOut), 64'd7);
    chk({tag, "_done_req"}, 64'(MemReqOut), 64'h0);
  endtask

  initial begin : driver
    Rst = 0; set_idle(); MemReadyIn = 0; MemRdataIn = '0;
    cyc(); cyc();
    // Reset state, and hold forced low while reset is asserted
    set_op(7'b0000011, 3'd3, 64'h100, 64'd0, 64'd0, 5'd1, 64'd0);
    #1;
    chk("rst_hold", 64'(HoldFlagToCtrl), 64'h0);
    chk("rst_req", 64'(MemReqOut), 64'h0);
    chk("rst_en", 64'(RdWriteEnableOut), 64'h0);
    chk("rst_data", RdWriteDataOut, 64'h0);
    chk("rst_buserr", 64'(BusErrOut), 64'h0);
    chk("rst_mis", 64'(MisalignOut), 64'h0);
    Rst = 1; set_idle();
    cyc();

    // ALU passthrough
    set_op(7'b0110011, 3'd0, 64'd0, 64'd0, 64'd0, 5'd5, 64'h1234);
    #1 chk("alu_hold", 64'(HoldFlagToCtrl), 64'h0);
    cyc();
    set_idle();
    chk("alu_rd", 64'(RdAddrOut), 64'd5);
    chk("alu_en", 64'(RdWriteEnableOut), 64'h1);
    chk("alu_data", RdWriteDataOut, 64'h1234);
    cyc();

    do_byte_load(3'b000, 64'hFFFF_FFFF_FFFF_FF80, "lb");
    do_byte_load(3'b100, 64'h0000_0000_0000_0080, "lbu");

    // SH at EA 0x2006 with three wait cycles (ready lands on the last allowed cycle)
    set_op(7'b0100011, 3'b001, 64'h2000, 64'd6, 64'hBEEF, 5'd2, 64'd0);
    MemReadyIn = 0;
    #1 chk("sh_acc_hold", 64'(HoldFlagToCtrl), 64'h1);
    cyc();
    set_idle();
    chk("sh_addr", MemAddrOut, 64'h2000);
    chk("sh_we", 64'(MemWeOut), 64'h1);
    chk("sh_mask", 64'(MemWmaskOut), 64'hC0);
    chk("sh_wdata", MemWdataOut, 64'hBEEF_0000_0000_0000);
    for (int i = 0; i < 3; i++) begin
      chk("sh_wait_hold", 64'(HoldFlagToCtrl), 64'h1);
      cyc();
    end
    MemReadyIn = 1;
    #1 chk("sh_ready_hold", 64'(HoldFlagToCtrl), 64'h0);
    cyc();
    MemReadyIn = 0;
    chk("sh_en", 64'(RdWriteEnableOut), 64'h0);
    chk("sh_req_done", 64'(MemReqOut), 64'h0);
    chk("sh_no_buserr", 64'(BusErrOut), 64'h0);

    // Timeout with ready never asserted
    set_op(7'b0000011, 3'd3, 64'h3000, 64'd0, 64'd0, 5'd9, 64'd0);
    cyc();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      chk("to_hold", 64'(HoldFlagToCtrl), 64'h1);
      chk("to_req", 64'(MemReqOut), 64'h1);
      cyc();
    end
    chk("to_last_hold", 64'(HoldFlagToCtrl), 64'h0);
    chk("to_last_req", 64'(MemReqOut), 64'h1);
    cyc();
    chk("to_buserr", 64'(BusErrOut), 64'h1);
    chk("to_req_after", 64'(MemReqOut), 64'h0);
    chk("to_hold_after", 64'(HoldFlagToCtrl), 64'h0);
    chk("to_en", 64'(RdWriteEnableOut), 64'h0);
    cyc();
    chk("to_buserr_pulse", 64'(BusErrOut), 64'h0);

    // LW at EA 0x1002
    set_op(7'b0000011, 3'b010, 64'h1000, 64'd2, 64'd0, 5'd4, 64'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    #1 chk("mis_hold", 64'(HoldFlagToCtrl), 64'h0);
    cyc();
    set_idle();
    chk("mis_pulse", 64'(MisalignOut), 64'h1);
    chk("mis_req", 64'(MemReqOut), 64'h0);
    chk("mis_en", 64'(RdWriteEnableOut), 64'h0);
    cyc();
    chk("mis_pulse_end", 64'(MisalignOut), 64'h0);
`else
    #1 chk("mis_hold", 64'(HoldFlagToCtrl), 64'h1);
    cyc();
    set_idle();
    chk("mis_req", 64'(MemReqOut), 64'h1);
    chk("mis_addr", MemAddrOut, 64'h1000);
    chk("mis_mask", 64'(MemWmaskOut), 64'h0F);
    chk("mis_flag", 64'(MisalignOut), 64'h0);
    MemReadyIn = 1; MemRdataIn = 64'h1122_3344_5566_7788;
    cyc();
    MemReadyIn = 0;
    chk("mis_data", RdWriteDataOut, 64'h0000_0000_5566_7788);
    chk("mis_en", 64'(RdWriteEnableOut), 64'h1);
`endif

    // Reset in the second wait cycle of a load
    set_op(7'b0000011, 3'd3, 64'h4000, 64'd0, 64'd0, 5'd3, 64'd0);
    cyc();
    set_idle();
    cyc();
    Rst = 0;
    #1 chk("rreq_hold_in_rst", 64'(HoldFlagToCtrl), 64'h0);
    cyc();
    chk("rreq_req", 64'(MemReqOut), 64'h0);
    chk("rreq_en", 64'(RdWriteEnableOut), 64'h0);
    chk("rreq_data", RdWriteDataOut, 64'h0);
    chk("rreq_rd", 64'(RdAddrOut), 64'h0);
    Rst = 1;
    cyc();
    chk("rreq_idle", 64'(MemReqOut), 64'h0);

    // Randomized traffic; the compare process checks every cycle
    for (int c = 0; c < 4000; c++) begin
      case ($urandom_range(0, 4))
        0, 1:    OpCodeIn = 7'b0000011;
        2:       OpCodeIn = 7'b0100011;
        3:       OpCodeIn = 7'b0110011;
        default: OpCodeIn = 7'($urandom());
      endcase
      ValidIn         = ($urandom_range(0, 7) != 0);
      Funct3In        = 3'($urandom());
      Rs1ReadDataIn   = {$urandom(), $urandom()};
      ImmIn           = ($urandom_range(0, 3) == 0) ? {$urandom(), $urandom()}
                                                    : 64'($urandom_range(0, 16));
      Rs2ReadDataIn   = {$urandom(), $urandom()};
      RdAddrIn        = 5'($urandom());
      RdWriteEnableIn = 1'($urandom());
      RdWriteDataIn   = {$urandom(), $urandom()};
      MemReadyIn      = ($urandom_range(0, 9) < 4);
      MemRdataIn      = {$urandom(), $urandom()};
      Rst             = ($urandom_range(0, 199) != 0);
      cyc();
    end

    Rst = 1; set_idle(); MemReadyIn = 1;
    for (int i = 0; i < 6; i++) cyc();
    chk("end_req", 64'(MemReqOut), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- Memory stage sitting directly downstream of the execute stage.
- Consumes the execute stage's load/store side-band:
  - opcode, funct3, immediate, rs1/rs2 data, rd address/enable
  - ALU result
- Drives a single-outstanding, ready-handshaked 64-bit data-memory port.
- Stalls the pipeline while an access is in flight; presents registered results to write-back.

## Interface
Parameters:
- TIMEOUT, 256: maximum REQ-state cycles before the access is aborted with a bus error.

Ports:
- Clk  in  1  clock.
- Rst  in  1  reset; one clock, synchronous, active-low.
- ValidIn  in  1  execute-stage output valid.
- OpCodeIn  in  7  zero for non-memory instructions.
- Funct3In  in  3
- ImmIn  in  64
- Rs1ReadDataIn  in  64
- Rs2ReadDataIn  in  64
- RdAddrIn  in  5
- RdWriteEnableIn  in  1
- RdWriteDataIn  in  64  ALU result.
- HoldFlagToCtrl  out  1  stall request to the pipeline controller.
- RdAddrOut  out  5  registered, to write-back.
- RdWriteEnableOut  out  1  registered.
- RdWriteDataOut  out  64  registered.
- MemReqOut  out  1
- MemWeOut  out  1
- MemAddrOut  out  64  8-byte aligned.
- MemWdataOut  out  64
- MemWmaskOut  out  8  byte enables.
- MemReadyIn  in  1
- MemRdataIn  in  64
- BusErrOut  out  1  one-cycle pulse.
- MisalignOut  out  1  one-cycle pulse.

## Operation
Effective address and op decode:
- EA = Rs1ReadDataIn + ImmIn, mod 2^64.
- Load = opcode 0000011; store = opcode 0100011; anything else is non-memory.
- Load funct3: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- Store funct3: 000 SB, 001 SH, 010 SW, 011 SD.
- Any other funct3 is treated as a non-memory instruction.

State machine IDLE/REQ:
- **IDLE, ValidIn, non-memory:**
  - At the edge, RdAddrOut/RdWriteEnableOut/RdWriteDataOut take the inputs.
  - No hold.
- **IDLE, ValidIn, memory op:**
  - HoldFlagToCtrl = 1 combinationally.
  - At the edge, capture op, size, EA, rd, store data; go to REQ.
  - Write-back enable register is cleared (bubble).
- **IDLE, !ValidIn:** write-back enable register cleared.
- **REQ:**
  - MemReqOut = 1, with MemAddrOut, MemWeOut, MemWdataOut, MemWmaskOut held stable from capture registers.
  - Inputs are ignored.
  - HoldFlagToCtrl = !MemReadyIn.
- **REQ, MemReadyIn = 1 at an edge:**
  - Go to IDLE.
  - Load: RdWriteDataOut = extracted load data, RdWriteEnableOut = captured enable.
  - Store: RdWriteEnableOut = 0.

Bus formatting and load extraction:
- MemAddrOut = {EA[63:3], 3'b000}.
- MemWdataOut = rs2 << (8*EA[2:0]).
- MemWmaskOut = size mask (0x01/0x03/0x0F/0xFF) << EA[2:0].
- Load data = MemRdataIn >> (8*EA[2:0]), truncated to the access size.
  - Signed loads sign-extend; LBU/LHU/LWU zero-extend.

Timeout:
- A counter clears on entry to REQ and increments each REQ cycle without ready.
- When it reaches TIMEOUT-1 without ready:
  - Go to IDLE; BusErrOut = 1 for one cycle.
  - RdWriteEnableOut = 0; hold drops that cycle.
- Ready arriving on the same cycle as the timeout wins; the access completes normally.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, including MemReqOut, HoldFlagToCtrl (while Rst low), BusErrOut, MisalignOut.
- Reset asserted in REQ: MemReqOut drops at that edge; no write-back. Memory must tolerate an abandoned request.
- Latency, non-memory: 1 cycle, input to registered write-back.
- Latency, memory op: 1 accept cycle + (wait cycles + 1) in REQ. Zero-wait load result is visible 2 cycles after acceptance.
- Only one access is outstanding; MemReqOut never deasserts before ready except by timeout or reset.
- MemRdataIn is sampled only in the cycle MemReadyIn = 1.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - An access whose EA is not a multiple of its size issues no bus request; the state stays IDLE and there is no hold.
  - At the edge: MisalignOut = 1 for one cycle, RdWriteEnableOut = 0.
- MEM_MISALIGN_TRAP_EN undefined:
  - EA low bits are masked to natural alignment (EA & ~(size-1)) before use.
  - MisalignOut is tied to 0.

## Test plan
- **ALU passthrough:** opcode 0110011, rd 5, RdWriteDataIn 0x1234 → next cycle RdAddrOut 5, RdWriteEnableOut 1, RdWriteDataOut 0x1234, no hold.
- **LB sign extension:** rs1 0x1000, imm 3, MemReadyIn 1 immediately, MemRdataIn 0x00000000_80000000 → MemAddrOut 0x1000; RdWriteDataOut 0xFFFFFFFF_FFFFFF80 two cycles after accept. Repeat as LBU → 0x80.
- **SH with 3 wait cycles:** EA 0x2006, rs2 0xBEEF → MemWmaskOut 0xC0, MemWdataOut 0xBEEF_0000_0000_0000. Hold stays 1 for 4 cycles; RdWriteEnableOut 0 afterwards.
- **Timeout:** TIMEOUT 4, ready never asserted → BusErrOut pulse after 4 REQ cycles, MemReqOut 0 and hold 0 after that.
- **Misalign (macro on):** LW at EA 0x1002 → MisalignOut pulse, MemReqOut stays 0. Macro off → MemAddrOut 0x1000, mask 0x0F.
- **Reset during REQ:** Rst low in the second wait cycle → MemReqOut, HoldFlagToCtrl and write-back outputs all 0 next cycle; state IDLE.
